// File: rtl/int_perceptron_trainer.sv
// Fixed-point perceptron that learns its weights on chip from a stored training set.
// Latency: 2*N_SAMPLES+1 cycles per epoch during training; inference is registered with 1 cycle of latency and never stalls.
// Backpressure: none; while busy, start, smp_wr, w_wr and inf_valid are dropped.
module int_perceptron_trainer #(
    parameter int TAM        = 16,
    parameter int FRAC       = 12,
    parameter int N_IN       = 2,
    parameter int N_SAMPLES  = 4,
    parameter int MAX_EPOCHS = 16,
    parameter int ETA_SHIFT  = 0,
    localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int WW = $clog2(N_IN + 1),
    localparam int EW = $clog2(MAX_EPOCHS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      smp_wr,
    input  logic [SW-1:0]             smp_idx,
    input  logic [N_IN*TAM-1:0]       smp_x,
    input  logic                      smp_d,
    input  logic                      w_wr,
    input  logic [WW-1:0]             w_idx,
    input  logic [TAM-1:0]            w_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      converged,
    output logic [EW-1:0]             epochs,
    output logic [(N_IN+1)*TAM-1:0]   w_out,
    input  logic                      inf_valid,
    input  logic [N_IN*TAM-1:0]       inf_x,
    output logic [TAM-1:0]            inf_y,
    output logic                      inf_y_valid
);
    localparam int PW = 2 * TAM;
    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam logic signed [PW-1:0]  MAXV  = PW'((64'sd1 <<< (TAM - 1)) - 64'sd1);
    localparam logic signed [PW-1:0]  MINV  = -MAXV - PW'(1);
    localparam logic signed [TAM-1:0] ONE_T = TAM'(1 << FRAC);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EVAL   = 3'd1;
    localparam logic [2:0] S_UPDATE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    function automatic logic signed [TAM-1:0] sat(input logic signed [PW-1:0] a);
        logic signed [PW-1:0] r;
        if (a > MAXV)      r = MAXV;
        else if (a < MINV) r = MINV;
        else               r = a;
        return r[TAM-1:0];
    endfunction

    // Products are saturated individually before accumulation so a single
    // huge term cannot wrap the running sum.
    function automatic logic signed [TAM-1:0] neuron(input logic [(N_IN+1)*TAM-1:0] wv,
                                                     input logic [N_IN*TAM-1:0]     xv);
        logic signed [PW-1:0]  acc;
        logic signed [PW-1:0]  p;
        logic signed [TAM-1:0] t;
        t   = wv[TAM-1:0];
        acc = PW'(t);
        for (int k = 0; k < N_IN; k++) begin
            p   = $signed(wv[(k+1)*TAM +: TAM]) * $signed(xv[k*TAM +: TAM]);
            p   = p >>> FRAC;
            t   = sat(p);
            acc = acc + PW'(t);
        end
        return sat(acc);
    endfunction

    function automatic logic signed [TAM-1:0] upd(input logic signed [TAM-1:0] base,
                                                  input logic signed [TAM-1:0] x,
                                                  input logic                  neg);
        logic signed [TAM-1:0] dlt;
        logic signed [PW-1:0]  sum;
        dlt = x >>> ETA_SHIFT;
        sum = neg ? (PW'(base) - PW'(dlt)) : (PW'(base) + PW'(dlt));
        return sat(sum);
    endfunction

    logic [2:0]                 state;
    logic [SW-1:0]              s;
    logic [CW-1:0]              err_cnt;
    logic                       err_nz;
    logic                       err_neg;
    logic [(N_IN+1)*TAM-1:0]    w_q;
    logic [(N_IN+1)*TAM-1:0]    w_upd;
    logic [N_IN*TAM-1:0]        mem_x [N_SAMPLES];
    logic                       mem_d [N_SAMPLES];
    logic [N_IN*TAM-1:0]        cur_x;
    logic                       cur_d;
    logic signed [TAM-1:0]      eval_v;
    logic signed [TAM-1:0]      inf_v;
    logic                       idle;

    assign idle   = (state == S_IDLE);
    assign cur_x  = mem_x[s];
    assign cur_d  = mem_d[s];
    assign eval_v = neuron(w_q, cur_x);
    assign inf_v  = neuron(w_q, inf_x);
    assign w_out  = w_q;

    always_comb begin
        w_upd = w_q;
        w_upd[TAM-1:0] = upd(w_q[TAM-1:0], ONE_T, err_neg);
        for (int k = 1; k <= N_IN; k++)
            w_upd[k*TAM +: TAM] = upd(w_q[k*TAM +: TAM], cur_x[(k-1)*TAM +: TAM], err_neg);
    end

    // Training memory has no reset so a stored set survives a reset.
    always_ff @(posedge clk) begin
        if (idle && smp_wr && (int'(smp_idx) < N_SAMPLES)) begin
            mem_x[smp_idx] <= smp_x;
            mem_d[smp_idx] <= smp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            w_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            epochs    <= '0;
            s         <= '0;
            err_cnt   <= '0;
            err_nz    <= 1'b0;
            err_neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (w_wr && (int'(w_idx) <= N_IN))
                        w_q[w_idx*TAM +: TAM] <= w_data;
                    if (start) begin
                        state     <= S_EVAL;
                        s         <= '0;
                        err_cnt   <= '0;
                        epochs    <= '0;
                        converged <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_EVAL: begin
                    // y = ONE when v >= 0; a miss with y = ONE means d = 0, i.e. e = -1
                    err_nz  <= (cur_d != ~eval_v[TAM-1]);
                    err_neg <= ~eval_v[TAM-1];
                    state   <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (err_nz) begin
                        w_q     <= w_upd;
                        err_cnt <= err_cnt + CW'(1);
                    end
                    if (s == SW'(N_SAMPLES - 1)) begin
                        state <= S_CHECK;
                    end else begin
                        s     <= s + SW'(1);
                        state <= S_EVAL;
                    end
                end
                S_CHECK: begin
                    epochs <= epochs + EW'(1);
                    if (err_cnt == '0) begin
                        converged <= 1'b1;
                        state     <= S_FIN;
                    end else if (epochs + EW'(1) == EW'(MAX_EPOCHS)) begin
                        converged <= 1'b0;
                        state     <= S_FIN;
                    end else begin
                        err_cnt <= '0;
                        s       <= '0;
                        state   <= S_EVAL;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inf_y       <= '0;
            inf_y_valid <= 1'b0;
        end else begin
            inf_y_valid <= inf_valid && idle;
            if (inf_valid && idle)
                inf_y <= inf_v[TAM-1] ? '0 : ONE_T;
        end
    end
endmodule

// File: tb/tb_int_perceptron_trainer.sv
// Directed bench for int_perceptron_trainer: OR/XOR training, inference, saturation, busy masking, mid-run reset.
module tb_int_perceptron_trainer;
    logic        clk = 1'b0;
    logic        rst_n, smp_wr, smp_d, w_wr, start, inf_valid;
    logic [1:0]  smp_idx, w_idx;
    logic [31:0] smp_x, inf_x;
    logic [15:0] w_data;
    logic        busy, done, converged;
    logic [4:0]  epochs;
    logic [47:0] w_out;
    logic [15:0] inf_y;
    logic        inf_y_valid;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [15:0] ONE = 16'h1000;
    localparam logic [47:0] OR_W = {16'h1000, 16'h1000, 16'hF000};

    int_perceptron_trainer dut (
        .clk(clk), .rst_n(rst_n), .smp_wr(smp_wr), .smp_idx(smp_idx), .smp_x(smp_x),
        .smp_d(smp_d), .w_wr(w_wr), .w_idx(w_idx), .w_data(w_data), .start(start),
        .busy(busy), .done(done), .converged(converged), .epochs(epochs), .w_out(w_out),
        .inf_valid(inf_valid), .inf_x(inf_x), .inf_y(inf_y), .inf_y_valid(inf_y_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_sample(input logic [1:0] idx, input logic [15:0] x0,
                                input logic [15:0] x1, input logic d);
        smp_wr = 1'b1; smp_idx = idx; smp_x = {x1, x0}; smp_d = d;
        tick();
        smp_wr = 1'b0;
    endtask

    task automatic write_weight(input logic [1:0] idx, input logic [15:0] val);
        w_wr = 1'b1; w_idx = idx; w_data = val;
        tick();
        w_wr = 1'b0;
    endtask

    task automatic load_set(input logic [3:0] d);
        write_sample(2'd0, 16'h0, 16'h0, d[0]);
        write_sample(2'd1, 16'h0, ONE,   d[1]);
        write_sample(2'd2, ONE,   16'h0, d[2]);
        write_sample(2'd3, ONE,   ONE,   d[3]);
    endtask

    task automatic infer(input logic [15:0] x0, input logic [15:0] x1);
        inf_valid = 1'b1; inf_x = {x1, x0};
        tick();
        inf_valid = 1'b0;
    endtask

    // Pulses start and counts cycles from the start edge to done; optionally
    // pokes every input that must be ignored while busy.
    task automatic run_training(input int poke_at, output int done_cyc,
                                output bit busy_ok, output bit iv_seen);
        done_cyc = -1; busy_ok = 1'b1; iv_seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == poke_at) begin
                start = 1'b1; inf_valid = 1'b1; inf_x = {ONE, ONE};
                smp_wr = 1'b1; smp_idx = 2'd0; smp_x = {ONE, ONE}; smp_d = 1'b1;
                w_wr = 1'b1; w_idx = 2'd0; w_data = 16'h7FFF;
            end
            tick();
            start = 1'b0; inf_valid = 1'b0; smp_wr = 1'b0; w_wr = 1'b0;
            if (inf_y_valid) iv_seen = 1'b1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic check_or_result(input string tag, input int done_cyc);
        vectors++;
        if (done_cyc !== 37) begin
            miscompares++; $display("FAIL %s_done_cycle: got %0d expected 37", tag, done_cyc);
        end
        vectors++;
        if (converged !== 1'b1) begin
            miscompares++; $display("FAIL %s_converged: got %b expected 1", tag, converged);
        end
        vectors++;
        if (epochs !== 5'd4) begin
            miscompares++; $display("FAIL %s_epochs: got %0d expected 4", tag, epochs);
        end
        vectors++;
        if (w_out !== OR_W) begin
            miscompares++; $display("FAIL %s_weights: got %h expected %h", tag, w_out, OR_W);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL %s_done_width: got done=%b busy=%b expected 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, done, converged, inf_y_valid} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, converged, inf_y_valid});
        end
        vectors++;
        if (epochs !== 5'd0) begin
            miscompares++; $display("FAIL reset_epochs: got %0d expected 0", epochs);
        end
        vectors++;
        if (w_out !== 48'h0) begin
            miscompares++; $display("FAIL reset_weights: got %h expected 0", w_out);
        end
        vectors++;
        if (inf_y !== 16'h0) begin
            miscompares++; $display("FAIL reset_inf_y: got %h expected 0", inf_y);
        end
    endtask

    task automatic test_or_training();
        int dc; bit bok; bit ivs;
        load_set(4'b1110);
        run_training(0, dc, bok, ivs);
        vectors++;
        if (bok !== 1'b1) begin
            miscompares++; $display("FAIL or_busy: got busy drop expected busy held");
        end
        check_or_result("or", dc);
    endtask

    task automatic test_inference();
        logic [15:0] xs0 [4] = '{16'h0, ONE, 16'h0, ONE};
        logic [15:0] xs1 [4] = '{16'h0, 16'h0, ONE, ONE};
        logic [15:0] exp_y [4] = '{16'h0, ONE, ONE, ONE};
        for (int i = 0; i < 4; i++) begin
            inf_valid = 1'b1; inf_x = {xs1[i], xs0[i]};
            tick();
            vectors++;
            if (inf_y_valid !== 1'b1 || inf_y !== exp_y[i]) begin
                miscompares++;
                $display("FAIL inf_b2b_%0d: got valid=%b y=%h expected valid=1 y=%h", i, inf_y_valid, inf_y, exp_y[i]);
            end
        end
        inf_valid = 1'b0;
        tick();
        vectors++;
        if (inf_y_valid !== 1'b0) begin
            miscompares++; $display("FAIL inf_valid_drop: got %b expected 0", inf_y_valid);
        end
    endtask

    task automatic test_xor();
        int dc; bit bok; bit ivs;
        do_reset();
        load_set(4'b0110);
        run_training(0, dc, bok, ivs);
        vectors++;
        if (dc !== 145) begin
            miscompares++; $display("FAIL xor_done_cycle: got %0d expected 145", dc);
        end
        vectors++;
        if (converged !== 1'b0 || epochs !== 5'd16) begin
            miscompares++; $display("FAIL xor_result: got conv=%b epochs=%0d expected conv=0 epochs=16", converged, epochs);
        end
        vectors++;
        if (bok !== 1'b1) begin
            miscompares++; $display("FAIL xor_busy: got busy drop expected busy held");
        end
    endtask

    task automatic test_saturation();
        write_weight(2'd1, 16'h7FFF);
        write_weight(2'd0, 16'h7FFF);
        write_weight(2'd2, 16'h0000);
        infer(16'h7FFF, 16'h0);
        vectors++;
        if (inf_y !== ONE) begin
            miscompares++; $display("FAIL sat_pos: got %h expected %h", inf_y, ONE);
        end
        write_weight(2'd0, 16'h8000);
        write_weight(2'd1, 16'h8000);
        infer(16'h7FFF, 16'h0);
        vectors++;
        if (inf_y !== 16'h0) begin
            miscompares++; $display("FAIL sat_neg: got %h expected 0", inf_y);
        end
        // v = -1.0 + 1.0 = 0 sits exactly on the activation boundary
        write_weight(2'd0, 16'hF000);
        write_weight(2'd1, ONE);
        infer(ONE, 16'h0);
        vectors++;
        if (inf_y !== ONE) begin
            miscompares++; $display("FAIL act_zero: got %h expected %h", inf_y, ONE);
        end
        infer(16'h0, ONE);
        vectors++;
        if (inf_y !== 16'h0) begin
            miscompares++; $display("FAIL act_neg: got %h expected 0", inf_y);
        end
    endtask

    task automatic test_busy_ignored();
        int dc; bit bok; bit ivs;
        do_reset();
        load_set(4'b1110);
        run_training(12, dc, bok, ivs);
        vectors++;
        if (ivs !== 1'b0) begin
            miscompares++; $display("FAIL busy_inf_valid: got inf_y_valid pulse expected none");
        end
        check_or_result("busy_poke", dc);
    endtask

    task automatic test_reset_mid_run();
        int dc; bit bok; bit ivs; bit saw_done;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || w_out !== 48'h0 || done !== 1'b0) begin
            miscompares++; $display("FAIL midreset_state: got busy=%b done=%b w=%h expected 0 0 0", busy, done, w_out);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++; $display("FAIL midreset_no_done: got done pulse expected none");
        end
        run_training(0, dc, bok, ivs);
        check_or_result("restart", dc);
    endtask

    initial begin
        rst_n = 1'b0; smp_wr = 1'b0; smp_idx = '0; smp_x = '0; smp_d = 1'b0;
        w_wr = 1'b0; w_idx = '0; w_data = '0; start = 1'b0; inf_valid = 1'b0; inf_x = '0;
        test_reset();
        test_or_training();
        test_inference();
        test_xor();
        test_saturation();
        test_busy_ignored();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/int_perceptron_trainer.md
Name: int_perceptron_trainer

Overview:
- Fixed-point perceptron with on-chip training; successor of the fixed-weight 4-sample int neuron.
- Parametrised input count, sample depth, learning rate and epoch limit.
- Stores a training set, runs the perceptron learning rule epoch by epoch until zero errors or the epoch limit, then serves registered inference with the learned weights.
- Uses the codebase step activation: output 1.0 when v ≥ 0, else 0.

Parameters:
- TAM, 16: data/weight width, signed two's complement.
- FRAC, 12: fractional bits; ONE = 1<<FRAC (0x1000 at defaults).
- N_IN, 2: inputs per sample.
- N_SAMPLES, 4: training-set depth.
- MAX_EPOCHS, 16: epoch limit.
- ETA_SHIFT, 0: learning rate = 2^-ETA_SHIFT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- smp_wr  in  1  write one training sample.
- smp_idx  in  clog2(N_SAMPLES)  sample slot.
- smp_x  in  N_IN*TAM  sample inputs; x[i] = smp_x[i*TAM +: TAM].
- smp_d  in  1  desired output (1 → ONE, 0 → 0).
- w_wr  in  1  preload one weight.
- w_idx  in  clog2(N_IN+1)  0 = bias w0; k = weight on x[k-1].
- w_data  in  TAM  weight value.
- start  in  1  start training (pulse).
- busy  out  1  training in progress.
- done  out  1  one-cycle pulse when training ends.
- converged  out  1  last run ended with a zero-error epoch.
- epochs  out  clog2(MAX_EPOCHS+1)  epochs completed in the last run.
- w_out  out  (N_IN+1)*TAM  current weights; w0 in LSB slice.
- inf_valid  in  1  inference request.
- inf_x  in  N_IN*TAM  inference inputs.
- inf_y  out  TAM  inference result (ONE or 0).
- inf_y_valid  out  1  result valid.

Behaviour:
- Reset values:
  - All weights 0; busy, done, converged, inf_y_valid = 0; epochs = 0; inf_y = 0; FSM returns to IDLE.
  - Sample memory is not reset; its contents are preserved across reset.
- States:
  - IDLE: accepts smp_wr, w_wr, inf_valid and start.
  - EVAL: evaluates sample s.
  - UPDATE: applies the weight correction for sample s.
  - CHECK: end-of-epoch decision.
  - FIN: asserts done, returns to IDLE.
- IDLE → EVAL on start:
  - Clears s, the per-epoch error count and epochs; busy = 1 from the next cycle.
  - Weights are not cleared; they start from current or preloaded values.
- EVAL:
  - v = w0 + Σ sat((w[k]*x[k-1]) >>> FRAC).
  - Each product is full 2*TAM signed, shifted arithmetically, and accumulated with ≥ clog2(N_IN+1) guard bits.
  - v saturates to TAM bits.
  - y = ONE if v[TAM-1] == 0, else 0.
  - Error e = d − y ∈ {−1, 0, +1}.
  - Registers e and goes to UPDATE.
- UPDATE:
  - If e ≠ 0: w[k] += e·(x[k-1] >>> ETA_SHIFT); w0 += e·(ONE >>> ETA_SHIFT). All additions saturate to TAM bits. Error count increments.
  - If s < N_SAMPLES−1: s++ and go to EVAL; otherwise go to CHECK.
- Epoch timing: 2·N_SAMPLES cycles per epoch plus 1 cycle for CHECK.
- CHECK:
  - epochs++.
  - If the error count is 0: converged = 1 → FIN.
  - Else if epochs == MAX_EPOCHS: converged = 0 → FIN.
  - Else: clear the error count, s = 0 → EVAL.
- FIN: done = 1 for one cycle, busy = 0, → IDLE. epochs and converged hold until the next start.
- Ignored while busy: start, smp_wr, w_wr, inf_valid.
- Priority in IDLE when asserted in the same cycle: w_wr applied before start; the run uses the new weight.
- Inference:
  - IDLE only; uses the same datapath as EVAL on current weights.
  - inf_y and inf_y_valid registered, 1-cycle latency; inf_y_valid = inf_valid delayed by 1 cycle, 0 otherwise.
  - Fully pipelined, so back-to-back requests give back-to-back results.
- Reset mid-training: the FSM returns to IDLE next edge; weights cleared; no done pulse.
- Activation boundary: v = 0 yields ONE.

Test Plan:
1. OR training (defaults): samples (0,0)→0, (0,ONE)→1, (ONE,0)→1, (ONE,ONE)→1; start from reset weights → done with converged = 1, epochs = 4, w0 = 0xF000, w1 = w2 = 0x1000; done exactly 37 cycles after the start edge (4 epochs × 9 cycles + FIN).
2. Inference after test 1: back-to-back inf_x = (0,0), (ONE,0), (0,ONE), (ONE,ONE) → inf_y = 0, 0x1000, 0x1000, 0x1000 on consecutive cycles, each 1 cycle after its request.
3. XOR set (d = 0, 1, 1, 0) → done with converged = 0, epochs = 16, busy high for the whole run.
4. Saturation: preload w1 = 0x7FFF, w0 = 0x7FFF; inference with x = (0x7FFF, 0) → v saturates to 0x7FFF (no wrap), inf_y = 0x1000. Then w0 = 0x8000, w1 = 0x8000, x = (0x7FFF, 0) → inf_y = 0.
5. Ignored inputs while busy: start, smp_wr, w_wr and inf_valid pulsed mid-run → no effect on the run, sample memory, weights or inf_y_valid; test 1 results unchanged.
6. Reset mid-run: drop rst_n during epoch 2 of test 1 → busy = 0 and w_out = 0 next cycle, no done pulse; restart → same result as test 1 (samples retained).
